bubble_host_reader: RTL and testbench
=====================================

Name: bubble_host_reader

Overview:
- Synthesizable host-side bubble-memory access controller. It is the initiator counterpart to the BubbleDrive8 emulator.
- It drives nBSEN, nREPEN and nBOOTEN with the game-board access timing.
- It samples DOUT0/DOUT1 once per bit cell and packs the samples into bytes.
- Used as the stimulus/checker engine in self-checking benches and in FPGA loopback tests against BubbleDrive8_top.

Parameters:
- SETUP_CYC, 19: MCLK cycles from nBSEN falling to the start of cell 0.
- REP_LOW_CYC, 344: nREPEN low width, in MCLK cycles from the start of a cell.
- CELL_CYC, 960: MCLK cycles per bit cell.
- SAMPLE_OFF, 700: cycle within a cell at which the synchronized DOUT is captured. Legal range is REP_LOW_CYC < SAMPLE_OFF < CELL_CYC.
- TAIL_CYC, 212: MCLK cycles nBSEN stays low after the last cell.
- DOUT_INVERT, 1: 1 means DOUT pins are active-low and are inverted before packing.

Ports:
- MCLK  in  1  system clock; all logic is on the rising edge.
- MRST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- boot_mode  in  1  1 = bootloader access, 0 = page access; latched on start.
- cell_count  in  16  number of bit cells to read; latched on start.
- abort  in  1  terminate the current access.
- nBSEN  out  1  bubble shift enable, active-low.
- nREPEN  out  1  replicator enable, active-low.
- nBOOTEN  out  1  bootloop enable, active-low; low for the whole access in boot mode.
- DOUT0  in  1  emulator data line 0.
- DOUT1  in  1  emulator data line 1.
- data_byte  out  8  packed byte.
- data_valid  out  1  one-cycle strobe qualifying data_byte and byte_index. There is no backpressure.
- byte_index  out  14  index of the byte being presented, starting at 0.
- data_partial  out  1  set with the final data_valid when that byte is zero-padded.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of an access, including an aborted one.
- aborted  out  1  set with done if the access ended by abort; cleared on the next start.

Behaviour:
- Reset values: nBSEN, nREPEN and nBOOTEN = 1; data_byte = 0; data_valid = 0; byte_index = 0; data_partial = 0; busy = 0; done = 0; aborted = 0. The FSM goes to IDLE and all counters clear.
- DOUT0/DOUT1 pass through a 2-flop synchronizer. The value captured at SAMPLE_OFF is the pin level from 2 cycles earlier.
- FSM states: IDLE -> SETUP -> CELL -> TAIL -> FIN -> IDLE.
- IDLE:
  - start with cell_count == 0 goes directly to FIN. No strobes are driven, done pulses, and there is no data_valid.
  - start with cell_count > 0 goes to SETUP. nBSEN goes low in the first SETUP cycle. nBOOTEN goes low in the same cycle if boot_mode = 1.
- SETUP: lasts SETUP_CYC cycles, then enters CELL with the cell counter at 0 and the phase counter at 0.
- CELL, replicator:
  - Phase counter runs 0..CELL_CYC-1.
  - nREPEN is low for phases 0..REP_LOW_CYC-1.
  - Page mode: only in cell 0. Boot mode: in every cell.
- CELL, sampling:
  - At phase SAMPLE_OFF, the synchronized DOUT0/DOUT1 (inverted if DOUT_INVERT = 1) shift into the packer.
  - Packing is LSB-first: cell k of a byte fills bit 2k from DOUT0 and bit 2k+1 from DOUT1.
  - After the 4th cell of a byte, data_valid rises on the next cycle. byte_index increments after each data_valid.
- CELL, exit: after cell cell_count-1 reaches phase CELL_CYC-1, go to TAIL.
  - If cell_count mod 4 != 0, the partial byte is emitted on entry to TAIL, zero-padded in the high bits, with data_partial = 1.
- TAIL: nBSEN stays low for TAIL_CYC cycles, then goes to FIN.
- FIN: nBSEN and nBOOTEN return to 1, done pulses for one cycle, then return to IDLE.
- abort in SETUP, CELL or TAIL:
  - Next cycle: nBSEN, nREPEN and nBOOTEN = 1, state = FIN, aborted = 1.
  - No further data_valid is produced, including partial bytes.
- abort in IDLE is ignored. start while busy is ignored.
- Simultaneous abort and a data_valid-generating sample: the byte is discarded.
- MRST mid-access: outputs go to their reset values immediately, without waiting for a clock.
- Counters:
  - Phase counter is clog2(CELL_CYC) bits wide.
  - Cell counter is 16 bits and compares against the latched cell_count.
  - byte_index wraps from 16383 to 0.

Decomposition:
- Package bubble_host_pkg:
  - FSM state enum.
  - Default timing constants: SETUP/REP_LOW/CELL/SAMPLE/TAIL.
  - Bit-ordering constant (DOUT0 = even bits).
- Sub-module bubble_host_packer: 2-bit-per-cell shift packer with flush/partial logic and the byte_index counter.
- The top module holds the FSM, timers and synchronizer.

Test Plan:
All tests use SETUP_CYC=3, REP_LOW_CYC=4, CELL_CYC=16, SAMPLE_OFF=10, TAIL_CYC=2, DOUT_INVERT=0.
- Page read: start, boot_mode=0, cell_count=8, DOUT pattern (D1,D0) per cell = 01,10,11,00,00,11,10,01.
  - Bytes 0x39 (idx 0) and 0x6C (idx 1).
  - nREPEN low exactly 4 cycles, starting 3 cycles after nBSEN falls.
  - done 3+128+2+1 cycles after start.
- Boot read: boot_mode=1, cell_count=4, DOUT1=0, DOUT0=1 every cell.
  - 4 nREPEN pulses, 16 cycles apart.
  - nBOOTEN low while nBSEN is low.
  - One byte 0x55.
- Partial: cell_count=6, all DOUT=1 -> 0xFF, then 0x0F with data_partial=1.
- Zero count: cell_count=0 -> done 1 cycle later, no strobes, no data_valid.
- Abort in cell 5 of 8 -> byte 0 emitted, byte 1 dropped; strobes high next cycle; done with aborted=1.
- MRST asserted during CELL -> nBSEN=nREPEN=nBOOTEN=1 before the next MCLK edge; start after release runs normally.

Source files
------------

// File: rtl/bubble_host_pkg.sv
// Shared types and default timing for the bubble-memory host reader.
// DOUT0 feeds the even bit of each packed cell pair, and DOUT1 feeds the odd bit.
package bubble_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CELL,
        ST_TAIL,
        ST_FIN
    } state_t;

    localparam int unsigned DEF_SETUP_CYC   = 19;
    localparam int unsigned DEF_REP_LOW_CYC = 344;
    localparam int unsigned DEF_CELL_CYC    = 960;
    localparam int unsigned DEF_SAMPLE_OFF  = 700;
    localparam int unsigned DEF_TAIL_CYC    = 212;

    localparam bit DOUT0_EVEN = 1'b1;

    // Orders one cell's two samples into their packed bit positions.
    function automatic logic [1:0] cell_pair(input logic d0, input logic d1);
        return DOUT0_EVEN ? {d1, d0} : {d0, d1};
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bubble_host_packer.sv
// Packs two bits per cell, LSB-first, into bytes.
// It also flushes a zero-padded partial byte and counts the byte index.
module bubble_host_packer
    import bubble_host_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        drop,
    input  logic        shift,
    input  logic        flush,
    input  logic        d0,
    input  logic        d1,
    output logic [7:0]  data_byte,
    output logic        data_valid,
    output logic [13:0] byte_index,
    output logic        data_partial
);

    logic [7:0] acc;
    logic [1:0] fill;
    logic [7:0] merged;

    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
        merged = acc | (8'(cell_pair(d0, d1)) << {fill, 1'b0});
    end

    // NOTE: sequential state uses <= so each flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            fill         <= '0;
            data_byte    <= '0;
            data_valid   <= 1'b0;
            byte_index   <= '0;
            data_partial <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            data_partial <= 1'b0;
            if (data_valid)
                byte_index <= byte_index + 14'd1;

            if (restart || drop) begin
                acc  <= '0;
                fill <= '0;
                if (restart)
                    byte_index <= '0;
            end else if (shift) begin
                if (fill == 2'd3) begin
                    data_byte  <= merged;
                    data_valid <= 1'b1;
                    acc        <= '0;
                    fill       <= '0;
                end else begin
                    acc  <= merged;
                    fill <= fill + 2'd1;
                end
            end else if (flush && fill != 2'd0) begin
                // The unfilled high bits of acc are already zero.
                data_byte    <= acc;
                data_valid   <= 1'b1;
                data_partial <= 1'b1;
                acc          <= '0;
                fill         <= '0;
            end
        end
    end

endmodule

// File: rtl/bubble_host_reader.sv
// Host-side bubble-memory access controller.
// It drives nBSEN, nREPEN and nBOOTEN, and samples DOUT0 and DOUT1 into bytes.
module bubble_host_reader
    import bubble_host_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned REP_LOW_CYC = DEF_REP_LOW_CYC,
    parameter int unsigned CELL_CYC    = DEF_CELL_CYC,
    parameter int unsigned SAMPLE_OFF  = DEF_SAMPLE_OFF,
    parameter int unsigned TAIL_CYC    = DEF_TAIL_CYC,
    parameter bit          DOUT_INVERT = 1'b1
) (
    input  logic        MCLK,
    input  logic        MRST,
    input  logic        start,
    input  logic        boot_mode,
    input  logic [15:0] cell_count,
    input  logic        abort,
    output logic        nBSEN,
    output logic        nREPEN,
    output logic        nBOOTEN,
    input  logic        DOUT0,
    input  logic        DOUT1,
    output logic [7:0]  data_byte,
    output logic        data_valid,
    output logic [13:0] byte_index,
    output logic        data_partial,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam int PW = $clog2(CELL_CYC);
    localparam int TW = $clog2(max_u(SETUP_CYC, TAIL_CYC) + 1);

    localparam logic [PW-1:0] PH_LAST    = PW'(CELL_CYC - 1);
    localparam logic [PW-1:0] PH_SAMPLE  = PW'(SAMPLE_OFF);
    localparam logic [PW-1:0] PH_REP_END = PW'(REP_LOW_CYC - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] TAIL_LAST  = TW'(TAIL_CYC - 1);

    state_t        state;
    logic [PW-1:0] phase;
    logic [TW-1:0] timer;
    logic [15:0]   cell_idx;
    logic [15:0]   cell_cnt;
    logic          boot_lat;
    logic [1:0]    sync0;
    logic [1:0]    sync1;

    logic kill;
    logic last_cell;
    logic at_last_phase;
    logic shift;
    logic flush;
    logic restart;

    always_ff @(posedge MCLK or posedge MRST) begin
        if (MRST) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= {DOUT1, DOUT0};
            sync1 <= sync0;
        end
    end

    assign kill          = abort && (state inside {ST_SETUP, ST_CELL, ST_TAIL});
    assign at_last_phase = (phase == PH_LAST);
    assign last_cell     = (cell_idx == cell_cnt - 16'd1);
    // An abort in the same cycle as the sample or the exit discards the pending byte.
    assign shift         = (state == ST_CELL) && (phase == PH_SAMPLE) && !abort;
    assign flush         = (state == ST_CELL) && at_last_phase && last_cell && !abort;
    assign restart       = (state == ST_IDLE) && start;

    always_ff @(posedge MCLK or posedge MRST) begin
        if (MRST) begin
            state    <= ST_IDLE;
            phase    <= '0;
            timer    <= '0;
            cell_idx <= '0;
            cell_cnt <= '0;
            boot_lat <= 1'b0;
            nBSEN    <= 1'b1;
            nREPEN   <= 1'b1;
            nBOOTEN  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state   <= ST_FIN;
                nBSEN   <= 1'b1;
                nREPEN  <= 1'b1;
                nBOOTEN <= 1'b1;
                done    <= 1'b1;
                aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        cell_cnt <= cell_count;
                        boot_lat <= boot_mode;
                        aborted  <= 1'b0;
                        busy     <= 1'b1;
                        timer    <= '0;
                        if (cell_count == 16'd0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_SETUP;
                            nBSEN   <= 1'b0;
                            nBOOTEN <= !boot_mode;
                        end
                    end
                    ST_SETUP: begin
                        if (timer == SETUP_LAST) begin
                            state    <= ST_CELL;
                            phase    <= '0;
                            cell_idx <= '0;
                            nREPEN   <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_CELL: begin
                        if (at_last_phase) begin
                            if (last_cell) begin
                                state <= ST_TAIL;
                                timer <= '0;
                            end else begin
                                phase    <= '0;
                                cell_idx <= cell_idx + 16'd1;
                                // In page mode the replicator fires only in cell 0.
                                nREPEN   <= !boot_lat;
                            end
                        end else begin
                            phase <= phase + PW'(1);
                            if (phase == PH_REP_END)
                                nREPEN <= 1'b1;
                        end
                    end
                    ST_TAIL: begin
                        if (timer == TAIL_LAST) begin
                            state   <= ST_FIN;
                            done    <= 1'b1;
                            nBSEN   <= 1'b1;
                            nBOOTEN <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_FIN: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    bubble_host_packer u_packer (
        .clk          (MCLK),
        .rst          (MRST),
        .restart      (restart),
        .drop         (kill),
        .shift        (shift),
        .flush        (flush),
        .d0           (sync1[0] ^ DOUT_INVERT),
        .d1           (sync1[1] ^ DOUT_INVERT),
        .data_byte    (data_byte),
        .data_valid   (data_valid),
        .byte_index   (byte_index),
        .data_partial (data_partial)
    );

endmodule

// File: tb/tb_bubble_host_reader.sv
// Directed bench for bubble_host_reader with short timing.
// The timing is SETUP=3, REP_LOW=4, CELL=16, SAMPLE=10, TAIL=2, and DOUT is not inverted.
module tb_bubble_host_reader;

    logic        MCLK = 1'b0;
    logic        MRST = 1'b1;
    logic        start = 1'b0;
    logic        boot_mode = 1'b0;
    logic [15:0] cell_count = '0;
    logic        abort = 1'b0;
    logic        DOUT0 = 1'b0;
    logic        DOUT1 = 1'b0;
    logic        nBSEN, nREPEN, nBOOTEN;
    logic [7:0]  data_byte;
    logic        data_valid;
    logic [13:0] byte_index;
    logic        data_partial;
    logic        busy, done, aborted;

    bubble_host_reader #(
        .SETUP_CYC(3), .REP_LOW_CYC(4), .CELL_CYC(16),
        .SAMPLE_OFF(10), .TAIL_CYC(2), .DOUT_INVERT(1'b0)
    ) dut (
        .MCLK(MCLK), .MRST(MRST), .start(start), .boot_mode(boot_mode),
        .cell_count(cell_count), .abort(abort),
        .nBSEN(nBSEN), .nREPEN(nREPEN), .nBOOTEN(nBOOTEN),
        .DOUT0(DOUT0), .DOUT1(DOUT1),
        .data_byte(data_byte), .data_valid(data_valid), .byte_index(byte_index),
        .data_partial(data_partial), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [7:0]  b;
        logic [13:0] idx;
        logic        part;
    } dv_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc;
    dv_t  dv_q[$];
    int   rep_fall[$];
    int   bsen_fall, rep_low, bsen_low, boot_low, boot_bad, done_cnt, done_cyc;
    logic boot_exp, prev_rep, prev_bsen;

    always @(posedge MCLK) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge MCLK) begin
        if (data_valid) dv_q.push_back('{data_byte, byte_index, data_partial});
        if (!nREPEN) rep_low++;
        if (!nREPEN && prev_rep) rep_fall.push_back(cyc);
        if (!nBSEN) bsen_low++;
        if (!nBSEN && prev_bsen) bsen_fall = cyc;
        if (!nBOOTEN) boot_low++;
        if (nBOOTEN !== (boot_exp ? nBSEN : 1'b1)) boot_bad++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        prev_rep  = nREPEN;
        prev_bsen = nBSEN;
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic clear_mon(input logic boot);
        dv_q.delete();
        rep_fall.delete();
        rep_low = 0; bsen_low = 0; boot_low = 0; boot_bad = 0;
        done_cnt = 0; done_cyc = -1; bsen_fall = -1;
        boot_exp = boot; prev_rep = 1'b1; prev_bsen = 1'b1;
    endtask

    task automatic start_access(input logic boot, input logic [15:0] cnt);
        start_cyc  = cyc;
        start      = 1'b1;
        boot_mode  = boot;
        cell_count = cnt;
        tick();
        start = 1'b0;
    endtask

    // Each cell's {DOUT1,DOUT0} is taken from pairs[2k+:2] and held for the whole cell.
    task automatic drive_cells(input logic [15:0] pairs, input int n, input int pre);
        repeat (pre) tick();
        for (int k = 0; k < n; k++) begin
            {DOUT1, DOUT0} = pairs[2*k +: 2];
            repeat (16) tick();
        end
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (!done && t < limit) begin tick(); t++; end
        n_vec++;
        if (!done) begin n_err++; $display("FAIL done_timeout: got done=%b after %0d cycles, required 1", done, t); end
        tick();
    endtask

    task automatic test_reset();
        #13;
        n_vec++; if ({nBSEN, nREPEN, nBOOTEN} !== 3'b111) begin n_err++; $display("FAIL reset_strobes: got %b required 111", {nBSEN, nREPEN, nBOOTEN}); end
        n_vec++; if ({data_valid, data_partial, busy, done, aborted} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b required 00000", {data_valid, data_partial, busy, done, aborted}); end
        n_vec++; if ({data_byte, byte_index} !== 22'd0) begin n_err++; $display("FAIL reset_data: got %h/%0d required 00/0", data_byte, byte_index); end
        @(negedge MCLK) MRST = 1'b0;
        tick();
    endtask

    task automatic test_page_read();
        clear_mon(1'b0);
        start_access(1'b0, 16'd8);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL page_busy: got %b required 1", busy); end
        drive_cells(16'h6C39, 8, 3);
        wait_done(20);
        n_vec++; if (dv_q.size() != 2) begin n_err++; $display("FAIL page_nbytes: got %0d required 2", dv_q.size()); end
        n_vec++; if ({dv_q[0].b, dv_q[0].idx, dv_q[0].part} !== {8'h39, 14'd0, 1'b0}) begin n_err++; $display("FAIL page_byte0: got %h idx %0d p %b required 39 idx 0 p 0", dv_q[0].b, dv_q[0].idx, dv_q[0].part); end
        n_vec++; if ({dv_q[1].b, dv_q[1].idx, dv_q[1].part} !== {8'h6C, 14'd1, 1'b0}) begin n_err++; $display("FAIL page_byte1: got %h idx %0d p %b required 6c idx 1 p 0", dv_q[1].b, dv_q[1].idx, dv_q[1].part); end
        n_vec++; if (rep_low != 4 || rep_fall.size() != 1) begin n_err++; $display("FAIL page_rep_width: got %0d cycles / %0d pulses required 4 / 1", rep_low, rep_fall.size()); end
        n_vec++; if (rep_fall[0] != bsen_fall + 3) begin n_err++; $display("FAIL page_rep_delay: got %0d required %0d", rep_fall[0] - bsen_fall, 3); end
        n_vec++; if (done_cyc != start_cyc + 134) begin n_err++; $display("FAIL page_done_time: got %0d required %0d", done_cyc - start_cyc, 134); end
        n_vec++; if (bsen_low != 133 || boot_low != 0) begin n_err++; $display("FAIL page_strobes: got bsen_low %0d boot_low %0d required 133 0", bsen_low, boot_low); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL page_idle: got busy %b required 0", busy); end
    endtask

    task automatic test_boot_read();
        clear_mon(1'b1);
        start_access(1'b1, 16'd4);
        drive_cells(16'h5555, 4, 3);
        wait_done(20);
        n_vec++; if (dv_q.size() != 1 || dv_q[0].b !== 8'h55 || dv_q[0].idx !== 14'd0) begin n_err++; $display("FAIL boot_byte: got n=%0d %h idx %0d required n=1 55 idx 0", dv_q.size(), dv_q[0].b, dv_q[0].idx); end
        n_vec++; if (rep_fall.size() != 4 || rep_low != 16) begin n_err++; $display("FAIL boot_rep_count: got %0d pulses %0d cycles required 4 16", rep_fall.size(), rep_low); end
        n_vec++; if (rep_fall[1] - rep_fall[0] != 16 || rep_fall[3] - rep_fall[2] != 16) begin n_err++; $display("FAIL boot_rep_period: got %0d,%0d required 16,16", rep_fall[1] - rep_fall[0], rep_fall[3] - rep_fall[2]); end
        n_vec++; if (boot_bad != 0 || boot_low != 69) begin n_err++; $display("FAIL boot_booten: got bad %0d low %0d required 0 69", boot_bad, boot_low); end
        n_vec++; if (done_cyc != start_cyc + 70) begin n_err++; $display("FAIL boot_done_time: got %0d required 70", done_cyc - start_cyc); end
    endtask

    task automatic test_partial();
        clear_mon(1'b0);
        start_access(1'b0, 16'd6);
        start      = 1'b1;
        cell_count = 16'd0;
        tick();
        start = 1'b0;
        drive_cells(16'h0FFF, 6, 2);
        wait_done(20);
        n_vec++; if (dv_q.size() != 2) begin n_err++; $display("FAIL part_nbytes: got %0d required 2", dv_q.size()); end
        n_vec++; if ({dv_q[0].b, dv_q[0].idx, dv_q[0].part} !== {8'hFF, 14'd0, 1'b0}) begin n_err++; $display("FAIL part_byte0: got %h idx %0d p %b required ff idx 0 p 0", dv_q[0].b, dv_q[0].idx, dv_q[0].part); end
        n_vec++; if ({dv_q[1].b, dv_q[1].idx, dv_q[1].part} !== {8'h0F, 14'd1, 1'b1}) begin n_err++; $display("FAIL part_byte1: got %h idx %0d p %b required 0f idx 1 p 1", dv_q[1].b, dv_q[1].idx, dv_q[1].part); end
        n_vec++; if (done_cyc != start_cyc + 102 || done_cnt != 1) begin n_err++; $display("FAIL part_done: got t=%0d n=%0d required t=102 n=1", done_cyc - start_cyc, done_cnt); end
    endtask

    task automatic test_abort();
        clear_mon(1'b1);
        start_access(1'b1, 16'd8);
        drive_cells(16'hFFFF, 5, 3);
        {DOUT1, DOUT0} = 2'b11;
        repeat (2) tick();
        n_vec++; if (nREPEN !== 1'b0 || nBOOTEN !== 1'b0) begin n_err++; $display("FAIL abort_pre: got nREPEN %b nBOOTEN %b required 0 0", nREPEN, nBOOTEN); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++; if ({nBSEN, nREPEN, nBOOTEN} !== 3'b111) begin n_err++; $display("FAIL abort_strobes: got %b required 111", {nBSEN, nREPEN, nBOOTEN}); end
        n_vec++; if ({done, aborted, busy} !== 3'b111) begin n_err++; $display("FAIL abort_done: got done/aborted/busy %b required 111", {done, aborted, busy}); end
        tick();
        n_vec++; if ({done, aborted, busy} !== 3'b010) begin n_err++; $display("FAIL abort_idle: got done/aborted/busy %b required 010", {done, aborted, busy}); end
        repeat (40) tick();
        n_vec++; if (dv_q.size() != 1 || dv_q[0].b !== 8'hFF || done_cnt != 1) begin n_err++; $display("FAIL abort_bytes: got n=%0d %h done_n=%0d required n=1 ff done_n=1", dv_q.size(), dv_q[0].b, done_cnt); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++; if ({busy, done, nBSEN} !== 3'b001) begin n_err++; $display("FAIL abort_in_idle: got busy/done/nBSEN %b required 001", {busy, done, nBSEN}); end
    endtask

    task automatic test_zero_count();
        clear_mon(1'b0);
        start_access(1'b0, 16'd0);
        n_vec++; if ({done, busy, aborted, nBSEN} !== 4'b1101) begin n_err++; $display("FAIL zero_fin: got done/busy/aborted/nBSEN %b required 1101", {done, busy, aborted, nBSEN}); end
        repeat (3) tick();
        n_vec++; if (done_cnt != 1 || done_cyc != start_cyc + 1) begin n_err++; $display("FAIL zero_done: got n=%0d t=%0d required n=1 t=1", done_cnt, done_cyc - start_cyc); end
        n_vec++; if (dv_q.size() != 0 || rep_low != 0 || bsen_low != 0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_quiet: got dv %0d rep %0d bsen %0d busy %b required 0 0 0 0", dv_q.size(), rep_low, bsen_low, busy); end
    endtask

    task automatic test_mrst();
        clear_mon(1'b1);
        start_access(1'b1, 16'd4);
        {DOUT1, DOUT0} = 2'b11;
        repeat (21) tick();
        n_vec++; if ({nBSEN, nREPEN, nBOOTEN} !== 3'b000) begin n_err++; $display("FAIL mrst_pre: got %b required 000", {nBSEN, nREPEN, nBOOTEN}); end
        #2 MRST = 1'b1;
        #1;
        n_vec++; if ({nBSEN, nREPEN, nBOOTEN, busy} !== 4'b1110) begin n_err++; $display("FAIL mrst_async: got strobes/busy %b required 1110", {nBSEN, nREPEN, nBOOTEN, busy}); end
        @(negedge MCLK) MRST = 1'b0;
        tick();
        clear_mon(1'b0);
        start_access(1'b0, 16'd4);
        drive_cells(16'h0039, 4, 3);
        wait_done(20);
        n_vec++; if (dv_q.size() != 1 || {dv_q[0].b, dv_q[0].idx} !== {8'h39, 14'd0}) begin n_err++; $display("FAIL mrst_rerun_byte: got n=%0d %h idx %0d required n=1 39 idx 0", dv_q.size(), dv_q[0].b, dv_q[0].idx); end
        n_vec++; if (done_cyc != start_cyc + 70 || aborted !== 1'b0) begin n_err++; $display("FAIL mrst_rerun_done: got t=%0d aborted %b required t=70 aborted 0", done_cyc - start_cyc, aborted); end
    endtask

    initial begin
        clear_mon(1'b0);
        test_reset();
        test_page_read();
        test_boot_read();
        test_partial();
        test_abort();
        test_zero_count();
        test_mrst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
